// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift/inc/dec,
// iterative shift-add multiply and restoring divide.
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [3:0]         opcode,
   input  logic [WIDTH-1:0]   operandA,
   input  logic [WIDTH-1:0]   operandB,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic [3:0]         flags
);

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_DIV = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_INC = 4'b1010;
   localparam logic [3:0] OP_DEC = 4'b1011;

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] work;

   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH:0]     ext;
   logic               s_ill;
   logic               s_dbz;
   logic               s_cy;
   logic [3:0]         s_flg;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_df;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;

   assign ready = (state == IDLE);
   assign done  = (state == DONE);

   // Result and flags of every operation that completes in one cycle.
   always_comb begin
      hi    = '0;
      lo    = '0;
      ext   = '0;
      s_ill = 1'b0;
      s_dbz = 1'b0;
      s_cy  = 1'b0;
      unique case (opcode)
         OP_ADD: begin
            ext  = {1'b0, operandA} + {1'b0, operandB};
            lo   = ext[WIDTH-1:0];
            s_cy = ext[WIDTH];
         end
         OP_SUB: begin
            ext  = {1'b0, operandA} - {1'b0, operandB};
            lo   = ext[WIDTH-1:0];
            s_cy = ext[WIDTH];
         end
         OP_MUL: begin
            lo = '0;
         end
         OP_DIV: begin
            hi    = operandA;
            lo    = '1;
            s_dbz = 1'b1;
         end
         OP_AND: lo = operandA & operandB;
         OP_OR:  lo = operandA | operandB;
         OP_XOR: lo = operandA ^ operandB;
         OP_SHL: begin
            lo = (operandB >= WLIM) ? '0 : (operandA << operandB);
         end
         OP_SHR: begin
            lo = (operandB >= WLIM) ? '0 : (operandA >> operandB);
         end
         OP_INC: begin
            ext  = {1'b0, operandA} + {{WIDTH{1'b0}}, 1'b1};
            lo   = ext[WIDTH-1:0];
            s_cy = ext[WIDTH];
         end
         OP_DEC: begin
            ext  = {1'b0, operandA} - {{WIDTH{1'b0}}, 1'b1};
            lo   = ext[WIDTH-1:0];
            s_cy = ext[WIDTH];
         end
         default: s_ill = 1'b1;
      endcase
      s_flg = {s_ill, s_dbz, s_cy, ({hi, lo} == '0)};
   end

   // One multiply step and one divide step on the shared work register.
   always_comb begin
      mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]}
               + {1'b0, (work[0] ? a_q : {WIDTH{1'b0}})};
      mul_next = {mul_sum, work[WIDTH-1:1]};
      div_sh   = work[2*WIDTH-1:WIDTH-1];
      div_df   = div_sh - {1'b0, b_q};
      div_next = div_df[WIDTH]
               ? {div_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
               : {div_df[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
   end

   // Control FSM with operand latches, iteration counter and result regs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         work   <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  cnt <= '0;
                  a_q <= operandA;
                  b_q <= operandB;
                  if (opcode == OP_MUL) begin
                     work  <= {{WIDTH{1'b0}}, operandB};
                     state <= MUL;
                  end else if (opcode == OP_DIV && operandB != '0) begin
                     work  <= {{WIDTH{1'b0}}, operandA};
                     state <= DIV;
                  end else begin
                     result <= {hi, lo};
                     flags  <= s_flg;
                     state  <= DONE;
                  end
               end
            end
            MUL: begin
               work <= mul_next;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  result <= mul_next;
                  flags  <= {3'b000, (mul_next == '0)};
                  state  <= DONE;
               end
            end
            DIV: begin
               work <= div_next;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  result <= div_next;
                  flags  <= {3'b000, (div_next == '0)};
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to execute one operation.
REQ-005 SHALL have port opcode, input, 4 bits: operation select, encoded per REQ-013.
REQ-006 SHALL have ports operandA and operandB, input, WIDTH bits each: unsigned operands.
REQ-007 SHALL have port ready, output, 1 bit: high when a start will be accepted.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port result, output, 2*WIDTH bits: registered result.
REQ-010 SHALL have port flags, output, 4 bits: {illegal, div_by_zero, carry, zero}, registered with result.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, DONE; ready = (state==IDLE); done = (state==DONE).
REQ-012 SHALL accept only when start && ready; on acceptance latch opcode, operandA and operandB internally. Later input changes SHALL NOT affect the operation in flight.
REQ-013 SHALL decode opcodes as follows:
- 0001 add, 0010 sub, 0011 mul, 0100 div
- 0101 and, 0110 or, 0111 xor
- 1000 shl, 1001 shr (logical)
- 1010 inc A, 1011 dec A
- all other codes illegal
REQ-014 SHALL, for single-cycle ops (all except mul/div) and illegal codes, go IDLE->DONE on the accept edge; result is valid in the cycle after acceptance.
REQ-015 SHALL compute mul as a shift-add over exactly WIDTH iterations in state MUL; result = full 2*WIDTH-bit product; done asserts WIDTH+1 cycles after acceptance.
REQ-016 SHALL compute div as restoring division over exactly WIDTH iterations in state DIV; result = {remainder, quotient}; done asserts WIDTH+1 cycles after acceptance.
REQ-017 SHALL, for div with operandB==0, skip DIV and go directly to DONE with quotient all ones, remainder = operandA, div_by_zero=1.
REQ-018 SHALL produce WIDTH-bit arithmetic results zero-extended to 2*WIDTH:
- add: carry = carry-out
- sub/dec: carry = borrow (A<B, or A==0 for dec)
- inc: carry = carry-out (A all ones)
- all wrap modulo 2^WIDTH
REQ-019 SHALL zero-extend logic and shift results; a shift amount operandB >= WIDTH SHALL yield 0.
REQ-020 SHALL set zero=1 iff the full 2*WIDTH-bit result is 0.
REQ-021 SHALL, for illegal opcodes, produce result 0 and illegal=1.
REQ-022 SHALL clear flags not defined for an operation to 0.
REQ-023 SHALL go DONE->IDLE unconditionally after one cycle; a start during DONE/MUL/DIV SHALL be ignored, not queued.
REQ-024 SHALL hold result and flags stable from the DONE cycle until the next DONE; they update only on entry to DONE.
REQ-025 SHALL keep the iteration counter ceil(log2(WIDTH))+1 bits wide; it SHALL reset to 0 on every acceptance.

Reset
REQ-026 SHALL, on reset assertion at any time, immediately force state=IDLE, result=0, flags=0, done=0, counter=0; ready is 1 once reset deasserts.
REQ-027 SHALL abandon an in-flight mul/div on reset, with no done pulse for it.
REQ-028 SHALL accept a start in the first clock edge after reset deasserts.

Verification (WIDTH=16)
REQ-029 Bench SHALL check add/sub: A=10,B=5,op=0001 -> result 15, done at accept+1, flags 0000; then A=7,B=15,op=0010 -> result 0xFFF8, carry=1.
REQ-030 Bench SHALL check mul: A=0xFFFF,B=0xFFFF,op=0011 -> ready low 17 cycles, done at accept+17, result 0xFFFE0001; start pulsed mid-operation is ignored.
REQ-031 Bench SHALL check div: A=25,B=7,op=0100 -> result {16'd4,16'd3} at accept+17; A=9,B=0 -> result {16'd9,16'hFFFF}, div_by_zero=1, done at accept+1.
REQ-032 Bench SHALL check boundaries: inc A=0xFFFF -> result 0, zero=1, carry=1; dec A=0 -> 0xFFFF, carry=1; shl A=134,B=8 -> 0x8600; shr A=134,B=16 -> 0, zero=1.
REQ-033 Bench SHALL check illegal code and reset: op=1111 -> result 0, illegal=1; reset asserted at cycle 5 of a mul -> outputs 0 asynchronously, no done; next start accepted.
REQ-034 Bench SHALL check back-to-back operation: start held high continuously -> one op per IDLE cycle; results match a reference model for 1000 random ops at WIDTH=16 and WIDTH=8.
